sdram_arbiter: RTL and testbench

Round-robin arbiter that shares the single SDRAM command port between audio-path requesters: mixer, recorder, player. Each requester keeps the same read/write/addr/finished handshake it would use against the SDRAM controller directly. The arbiter latches one requester's command, owns the controller until `sd_finished`, and returns the completion to that requester only. It sits between the requester modules and the SDRAM controller wrapper.

---
 rtl/sdram_arbiter_if.sv | 66 ++++++
 rtl/sdram_arbiter.sv | 159 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if
//   Bundles the requester-side and controller-side handshakes of sdram_arbiter.
//
//   Requester side (one lane per requester, index 0 = mixer):
//     req_read / req_write      level requests, held until that lane's finished pulse
//     req_addr / req_writedata  per-lane command payload
//     req_readdata              broadcast copy of sd_readdata
//     req_finished              one-hot completion pulse to the granted lane
//   Controller side:
//     sd_read / sd_write        command to the SDRAM controller wrapper
//     sd_addr / sd_writedata    latched payload, stable for the whole command
//     sd_readdata               controller read data, valid while sd_finished=1
//     sd_finished               one-cycle completion from the controller
//
//   Modports:
//     master  the arbiter's view
//     slave   the view of the requesters plus the controller (the environment)
interface sdram_arbiter_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 23,
    parameter int unsigned DATA_W  = 32
);
    logic [NUM_REQ-1:0]             req_read;
    logic [NUM_REQ-1:0]             req_write;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_writedata;
    logic [DATA_W-1:0]              req_readdata;
    logic [NUM_REQ-1:0]             req_finished;

    logic                           sd_read;
    logic                           sd_write;
    logic [ADDR_W-1:0]              sd_addr;
    logic [DATA_W-1:0]              sd_writedata;
    logic [DATA_W-1:0]              sd_readdata;
    logic                           sd_finished;

    modport master (
        input  req_read,
        input  req_write,
        input  req_addr,
        input  req_writedata,
        output req_readdata,
        output req_finished,
        output sd_read,
        output sd_write,
        output sd_addr,
        output sd_writedata,
        input  sd_readdata,
        input  sd_finished
    );

    modport slave (
        output req_read,
        output req_write,
        output req_addr,
        output req_writedata,
        input  req_readdata,
        input  req_finished,
        input  sd_read,
        input  sd_write,
        input  sd_addr,
        input  sd_writedata,
        output sd_readdata,
        output sd_finished
    );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Round-robin arbiter sharing one SDRAM command port between NUM_REQ requesters
//   (mixer = 0, recorder, player). One requester's command is latched, driven to
//   the controller until sd_finished (or a watchdog abort), and the completion is
//   routed back to that requester only.
//
//   Ports:
//     i_clk        clock
//     i_rst        asynchronous active-high reset
//     bus          sdram_arbiter_if.master: requester lanes + controller port
//     grant_id     currently or last granted requester index
//     busy         1 while a command is owned by the controller
//     err_timeout  one-cycle pulse when the watchdog aborts a command
//
//   Parameters:
//     NUM_REQ  number of requesters (2..8)
//     ADDR_W   SDRAM word address width
//     DATA_W   data width
//     TIMEOUT  max cycles in BUSY before abort; 0 disables the watchdog
module sdram_arbiter #(
    parameter  int unsigned NUM_REQ = 3,
    parameter  int unsigned ADDR_W  = 23,
    parameter  int unsigned DATA_W  = 32,
    parameter  int unsigned TIMEOUT = 1024,
    localparam int unsigned IdW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    sdram_arbiter_if.master    bus,
    output logic [IdW-1:0]     grant_id,
    output logic               busy,
    output logic               err_timeout
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int unsigned     CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IdW-1:0]  LastId  = IdW'(NUM_REQ - 1);
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]     grant_q, grant_d;
    logic               cmd_rd_q, cmd_rd_d;
    logic               cmd_wr_q, cmd_wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [CntW-1:0]    wd_cnt_q, wd_cnt_d;

    logic [NUM_REQ-1:0] pend;
    logic [NUM_REQ-1:0] fin;
    logic [IdW-1:0]     sel;
    logic [IdW:0]       idx;
    logic               found;
    logic               timeout_hit;
    logic               done;

    assign pend = bus.req_read | bus.req_write;

    // First pending lane at or after rr_ptr, wrapping past the last lane.
    always_comb begin
        found = 1'b0;
        sel   = rr_ptr_q;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr_q} + (IdW + 1)'(k);
            if (idx >= (IdW + 1)'(NUM_REQ)) begin
                idx = idx - (IdW + 1)'(NUM_REQ);
            end
            if (!found && pend[idx[IdW-1:0]]) begin
                found = 1'b1;
                sel   = idx[IdW-1:0];
            end
        end
    end

    // An sd_finished in the abort cycle counts as a normal completion.
    assign timeout_hit = (TIMEOUT != 0) && (state_q == StBusy) &&
                         (wd_cnt_q == CntLast) && !bus.sd_finished;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        cmd_rd_d = cmd_rd_q;
        cmd_wr_d = cmd_wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wd_cnt_d = wd_cnt_q;
        fin      = '0;
        done     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d  = StBusy;
                    grant_d  = sel;
                    // Read wins when a lane raises both.
                    cmd_rd_d = bus.req_read[sel];
                    cmd_wr_d = bus.req_write[sel] & ~bus.req_read[sel];
                    addr_d   = bus.req_addr[sel];
                    wdata_d  = bus.req_writedata[sel];
                    wd_cnt_d = '0;
                end
            end
            StBusy: begin
                wd_cnt_d = wd_cnt_q + CntW'(1);
                done     = bus.sd_finished | timeout_hit;
                if (done) begin
                    fin[grant_q] = 1'b1;
                    rr_ptr_d     = (grant_q == LastId) ? '0 : grant_q + IdW'(1);
                    state_d      = StIdle;
                    cmd_rd_d     = 1'b0;
                    cmd_wr_d     = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cmd_rd_q <= 1'b0;
            cmd_wr_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cmd_rd_q <= cmd_rd_d;
            cmd_wr_q <= cmd_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    // Command strobes come straight from flops; they are cleared on leaving BUSY.
    assign bus.sd_read      = cmd_rd_q;
    assign bus.sd_write     = cmd_wr_q;
    assign bus.sd_addr      = addr_q;
    assign bus.sd_writedata = wdata_q;
    assign bus.req_readdata = bus.sd_readdata;
    assign bus.req_finished = fin;

    assign grant_id    = grant_q;
    assign busy        = (state_q == StBusy);
    assign err_timeout = timeout_hit;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
//   Randomized scoreboard bench for sdram_arbiter (3 requesters, TIMEOUT=8).
//   Stimulus tasks queue per-requester transaction plans and push the expected
//   grant sequence (round-robin reference model) into exp_q; a negedge monitor
//   pops and checks each command and its completion. A behavioural controller
//   with a small memory answers commands after a random or fixed latency.
module tb_sdram_arbiter;
    localparam int NR = 3;
    localparam int AW = 23;
    localparam int DW = 32;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant_id;
    logic       busy;
    logic       err_timeout;

    sdram_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sdram_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        bit            rd;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            to;
    } txn_t;

    txn_t          plan [NR][$];
    txn_t          exp_q [$];
    int            n_vec = 0;
    int            n_err = 0;
    int            model_ptr = 0;
    logic [DW-1:0] model_mem [logic [AW-1:0]];
    logic [DW-1:0] ctl_mem [logic [AW-1:0]];
    bit            ctl_hang = 1'b0;
    int            ctl_fixed_lat = 0;

    bit            mon_in_txn = 1'b0;
    bit            mon_exp_idle = 1'b0;
    int            mon_cyc = 0;
    txn_t          mon_cur;

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return {9'h15A, a} ^ 32'h0F0F_1234;
    endfunction

    function automatic txn_t mk(input int id, input bit rd, input bit wr,
                                input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.id = id; t.rd = rd; t.wr = wr; t.addr = a; t.wdata = d; t.to = 1'b0;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural SDRAM controller ----------------
    initial begin : controller
        int elapsed;
        int lat;
        elapsed = 0;
        lat = 1;
        bus.sd_finished = 1'b0;
        bus.sd_readdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                bus.sd_finished = 1'b0;
                elapsed = 0;
            end else if (bus.sd_finished) begin
                bus.sd_finished = 1'b0;
                bus.sd_readdata = $urandom();
                elapsed = 0;
            end else if (busy) begin
                elapsed++;
                if (elapsed == 1) lat = (ctl_fixed_lat != 0) ? ctl_fixed_lat : $urandom_range(1, 5);
                if (!ctl_hang && elapsed == lat) begin
                    bus.sd_finished = 1'b1;
                    if (bus.sd_read) begin
                        bus.sd_readdata = ctl_mem.exists(bus.sd_addr) ? ctl_mem[bus.sd_addr]
                                                                       : dflt(bus.sd_addr);
                    end else begin
                        bus.sd_readdata = $urandom();
                        if (bus.sd_write) ctl_mem[bus.sd_addr] = bus.sd_writedata;
                    end
                end else begin
                    bus.sd_readdata = $urandom();
                end
            end else begin
                elapsed = 0;
                bus.sd_readdata = $urandom();
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        logic [NR-1:0] fin_exp;
        logic [DW-1:0] rd_exp;
        bit            to_now;
        bit            fin_now;
        if (rst) begin
            mon_in_txn   = 1'b0;
            mon_exp_idle = 1'b0;
        end else begin
            chk("readdata_passthru", bus.req_readdata, bus.sd_readdata);
            if (mon_exp_idle) begin
                chk("idle_after_finish", busy, 0);
                mon_exp_idle = 1'b0;
            end
            if (busy) begin
                if (!mon_in_txn) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_grant: grant_id=%0d, expected no grant", grant_id);
                        mon_cur.id = -1;
                    end else begin
                        mon_cur = exp_q.pop_front();
                    end
                    mon_in_txn = 1'b1;
                    mon_cyc    = 0;
                end
                mon_cyc++;
                if (mon_cur.id >= 0) begin
                    to_now  = mon_cur.to && (mon_cyc == TO);
                    fin_now = bus.sd_finished || to_now;
                    fin_exp = fin_now ? (NR'(1) << mon_cur.id) : '0;
                    chk("grant_id", grant_id, mon_cur.id);
                    chk("sd_read", bus.sd_read, mon_cur.rd);
                    chk("sd_write", bus.sd_write, mon_cur.wr & ~mon_cur.rd);
                    chk("sd_addr", bus.sd_addr, mon_cur.addr);
                    chk("sd_writedata", bus.sd_writedata, mon_cur.wdata);
                    chk("req_finished", bus.req_finished, fin_exp);
                    chk("err_timeout", err_timeout, to_now);
                    if (fin_now) begin
                        if (!mon_cur.to) begin
                            if (mon_cur.rd) begin
                                rd_exp = model_mem.exists(mon_cur.addr) ? model_mem[mon_cur.addr]
                                                                        : dflt(mon_cur.addr);
                                chk("req_readdata", bus.req_readdata, rd_exp);
                            end else if (mon_cur.wr) begin
                                model_mem[mon_cur.addr] = mon_cur.wdata;
                            end
                        end
                        mon_in_txn   = 1'b0;
                        mon_exp_idle = 1'b1;
                    end else if (mon_cyc > TO) begin
                        n_vec++; n_err++;
                        $display("FAIL busy_overrun: still busy after %0d cycles, expected <= %0d",
                                 mon_cyc, TO);
                        mon_in_txn = 1'b0;
                    end
                end
            end else begin
                if (mon_in_txn && mon_cur.id >= 0) begin
                    n_vec++; n_err++;
                    $display("FAIL busy_dropped: idle after %0d busy cycles, expected a finish",
                             mon_cyc);
                end
                mon_in_txn = 1'b0;
                chk("idle_req_finished", bus.req_finished, 0);
                chk("idle_err_timeout", err_timeout, 0);
                chk("idle_sd_read", bus.sd_read, 0);
                chk("idle_sd_write", bus.sd_write, 0);
            end
        end
    end

    // ---------------- requester driving ----------------
    task automatic apply(input int r);
        if (plan[r].size() > 0) begin
            bus.req_read[r]      = plan[r][0].rd;
            bus.req_write[r]     = plan[r][0].wr;
            bus.req_addr[r]      = plan[r][0].addr;
            bus.req_writedata[r] = plan[r][0].wdata;
        end else begin
            bus.req_read[r]      = 1'b0;
            bus.req_write[r]     = 1'b0;
            bus.req_addr[r]      = '0;
            bus.req_writedata[r] = '0;
        end
    endtask

    // Finished lanes move to their next planned command at once; the lane in
    // service scrambles its payload and may drop its request.
    task automatic drive_step();
        for (int r = 0; r < NR; r++) begin
            if (bus.req_finished[r]) begin
                if (plan[r].size() > 0) void'(plan[r].pop_front());
                apply(r);
            end else if (busy && int'(grant_id) == r && plan[r].size() > 0) begin
                bus.req_addr[r]      = AW'($urandom());
                bus.req_writedata[r] = $urandom();
                if ($urandom_range(0, 3) == 0) begin
                    bus.req_read[r]  = 1'b0;
                    bus.req_write[r] = 1'b0;
                end
            end
        end
    endtask

    function automatic bit plans_empty();
        for (int r = 0; r < NR; r++) if (plan[r].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic flush();
        exp_q.delete();
        for (int r = 0; r < NR; r++) begin
            plan[r].delete();
            apply(r);
        end
    endtask

    // Reference model: every lane with work stays pending; each grant goes to
    // the first lane with work at or after the pointer, then the pointer moves
    // one past the winner.
    task automatic start_batch(input bit hang);
        int   k [NR];
        int   left;
        int   idx;
        txn_t t;
        ctl_hang = hang;
        left = 0;
        for (int r = 0; r < NR; r++) begin
            k[r] = 0;
            left += plan[r].size();
            apply(r);
        end
        while (left > 0) begin
            for (int s = 0; s < NR; s++) begin
                idx = (model_ptr + s) % NR;
                if (k[idx] < plan[idx].size()) begin
                    t    = plan[idx][k[idx]];
                    t.to = hang;
                    exp_q.push_back(t);
                    k[idx]++;
                    left--;
                    model_ptr = (idx + 1) % NR;
                    break;
                end
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            drive_step();
            n++;
            if (plans_empty() && exp_q.size() == 0 && !mon_in_txn) break;
            if (n >= budget) begin
                n_vec++; n_err++;
                $display("FAIL drain_timeout: %0d transactions still outstanding, expected 0",
                         exp_q.size());
                flush();
                break;
            end
        end
        @(negedge clk);
        drive_step();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sd_read"}, bus.sd_read, 0);
        chk({tag, "_sd_write"}, bus.sd_write, 0);
        chk({tag, "_sd_addr"}, bus.sd_addr, 0);
        chk({tag, "_sd_writedata"}, bus.sd_writedata, 0);
        chk({tag, "_req_finished"}, bus.req_finished, 0);
        chk({tag, "_err_timeout"}, err_timeout, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int total;
        int kind;
        logic [AW-1:0] a;
        rst = 1'b1;
        bus.req_read      = '0;
        bus.req_write     = '0;
        bus.req_addr      = '0;
        bus.req_writedata = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Contention from reset: 0 then 2.
        plan[0].push_back(mk(0, 1'b1, 1'b0, 23'h000010, 32'h0));
        plan[2].push_back(mk(2, 1'b1, 1'b0, 23'h000020, 32'h0));
        start_batch(1'b0);
        drain(200);

        // Fairness: three continuous requesters, nine grants.
        for (int j = 0; j < 3; j++) begin
            for (int r = 0; r < NR; r++) begin
                plan[r].push_back(mk(r, 1'b1, 1'b0, AW'(16 + 3 * j + r), 32'h0));
            end
        end
        start_batch(1'b0);
        drain(400);

        // Single read on lane 1, controller answers on the 4th BUSY cycle.
        ctl_mem[23'h000100]   = 32'hDEAD_BEEF;
        model_mem[23'h000100] = 32'hDEAD_BEEF;
        ctl_fixed_lat = 4;
        plan[1].push_back(mk(1, 1'b1, 1'b0, 23'h000100, 32'h0));
        start_batch(1'b0);
        @(posedge clk);
        #1;
        chk("single_busy", busy, 1);
        chk("single_sd_read", bus.sd_read, 1);
        chk("single_sd_addr", bus.sd_addr, 23'h000100);
        drain(200);
        ctl_fixed_lat = 0;

        // Write latch on lane 2; payload is scrambled once granted.
        plan[2].push_back(mk(2, 1'b0, 1'b1, 23'h7FFFFF, 32'h1234_5678));
        start_batch(1'b0);
        drain(200);

        // Read and write raised together on lane 0.
        plan[0].push_back(mk(0, 1'b1, 1'b1, 23'h7FFFFF, 32'hCAFE_F00D));
        start_batch(1'b0);
        drain(200);

        // Watchdog abort on lane 1.
        plan[1].push_back(mk(1, 1'b1, 1'b0, 23'h000055, 32'h0));
        start_batch(1'b1);
        drain(200);
        ctl_hang = 1'b0;

        // Reset while lane 2 holds the port; next grant goes to lowest pending.
        plan[2].push_back(mk(2, 1'b1, 1'b0, 23'h000066, 32'h0));
        start_batch(1'b1);
        repeat (4) begin
            @(negedge clk);
            drive_step();
        end
        rst = 1'b1;
        #1;
        check_all_zero("midbusy_reset");
        flush();
        model_ptr = 0;
        ctl_hang  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        plan[1].push_back(mk(1, 1'b1, 1'b0, 23'h000011, 32'h0));
        plan[2].push_back(mk(2, 1'b1, 1'b0, 23'h000022, 32'h0));
        start_batch(1'b0);
        drain(200);

        // Random batches.
        for (int b = 0; b < 25; b++) begin
            total = 0;
            for (int r = 0; r < NR; r++) begin
                for (int j = $urandom_range(0, 3); j > 0; j--) begin
                    kind = $urandom_range(0, 3);
                    a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom());
                    plan[r].push_back(mk(r, kind <= 1 || kind == 3, kind >= 2, a, $urandom()));
                    total++;
                end
            end
            if (total == 0) begin
                plan[0].push_back(mk(0, 1'b1, 1'b0, AW'($urandom_range(0, 15)), 32'h0));
                total = 1;
            end
            start_batch(1'b0);
            drain(100 + 30 * total);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
